multdiv_wb_sequencer: RTL and testbench

- Sequences the shared multi-cycle mult/div unit from the X stage.
- Holds the in-flight mult/div instruction in the P/W latch and detects RAW/WAW hazards against it.
- Arbitrates the single register-file write port between the pending mult/div result and the M/W stage.
- Drives the unit's start pulses, the pipeline stall, the M/W hold, and the P/W writeback request consumed by register-file control.

---
 rtl/md_pkg.sv | 29 ++
 rtl/multdiv_wb_sequencer_if.sv | 34 +++
 rtl/md_hazard_check.sv | 55 +++++
 rtl/multdiv_wb_sequencer.sv | 115 +++++++++++
 tb/tb_multdiv_wb_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - opcode, register, status and state definitions for the mult/div writeback sequencer
package md_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  localparam logic [4:0] ALU_MULT = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  localparam logic [2:0] STATUS_MULT = 3'd4;
  localparam logic [2:0] STATUS_DIV  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } md_state_e;

endpackage

// File: rtl/multdiv_wb_sequencer_if.sv
// rtl/multdiv_wb_sequencer_if.sv - pipeline/unit signals seen by the mult/div writeback sequencer
interface multdiv_wb_sequencer_if;

  logic [31:0] dx_ir;
  logic        dx_valid;
  logic        md_result_rdy;
  logic        md_exception;
  logic        mw_wants_write;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] pw_ir;
  logic        md_busy;
  logic        md_wr_en;
  logic [4:0]  md_wr_reg;
  logic        md_wr_status;
  logic [2:0]  md_status;
  logic        stall;
  logic        mw_hold;

  // sequencer side
  modport master (
    input  dx_ir, dx_valid, md_result_rdy, md_exception, mw_wants_write,
    output ctrl_mult, ctrl_div, pw_ir, md_busy, md_wr_en, md_wr_reg,
    output md_wr_status, md_status, stall, mw_hold
  );

  // pipeline / mult-div unit side
  modport slave (
    output dx_ir, dx_valid, md_result_rdy, md_exception, mw_wants_write,
    input  ctrl_mult, ctrl_div, pw_ir, md_busy, md_wr_en, md_wr_reg,
    input  md_wr_status, md_status, stall, mw_hold
  );

endinterface

// File: rtl/md_hazard_check.sv
// rtl/md_hazard_check.sv - decodes the D/X instruction and compares it against the pending P/W target
module md_hazard_check
  import md_pkg::*;
(
  input  logic [31:0] dx_ir,
  input  logic [4:0]  pend_reg,
  input  logic        pend_valid,
  output logic        raw,
  output logic        waw,
  output logic        is_md
);

  logic [4:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] aluop;
  logic [4:0] src_b;
  logic       wr_en;
  logic [4:0] wr_reg;
  logic       live;
  logic       unused_bits;

  assign opcode = dx_ir[31:27];
  assign rd     = dx_ir[26:22];
  assign rs     = dx_ir[21:17];
  assign rt     = dx_ir[16:12];
  assign aluop  = dx_ir[6:2];

  // shamt and low bits never take part in hazard decisions
  assign unused_bits = ^{dx_ir[11:7], dx_ir[1:0]};

  // second source and write target by opcode class; the first source is always rs
  always_comb begin
    src_b  = rs;
    wr_en  = 1'b0;
    wr_reg = rd;
    case (opcode)
      OP_ALU:                      begin src_b = rt; wr_en = 1'b1; end
      OP_BNE, OP_JR, OP_BLT, OP_SW: src_b = rd;
      OP_LW:                       begin src_b = rd; wr_en = 1'b1; end
      OP_ADDI:                     wr_en = 1'b1;
      OP_JAL:                      begin wr_en = 1'b1; wr_reg = REG_RA; end
      OP_J:                        src_b = rs;
      default:                     src_b = rs;
    endcase
  end

  // r0 is never a real dependency
  assign live  = pend_valid && (pend_reg != 5'd0);
  assign raw   = live && ((rs == pend_reg) || (src_b == pend_reg));
  assign waw   = live && wr_en && (wr_reg == pend_reg);
  assign is_md = (opcode == OP_ALU) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));

endmodule

// File: rtl/multdiv_wb_sequencer.sv
// rtl/multdiv_wb_sequencer.sv - issues mult/div ops, tracks the in-flight op and arbitrates its writeback
module multdiv_wb_sequencer
  import md_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic                   clock,
  input logic                   reset,
  multdiv_wb_sequencer_if.master bus
);

  md_state_e        state;
  md_state_e        state_nxt;
  logic [31:0]      pw_ir_q;
  logic [CNT_W-1:0] cnt;
  logic             exc;
  logic             dx_is_md;
  logic             raw;
  logic             waw;
  logic             issue;
  logic             timeout_hit;
  logic             pw_div;
  logic             pend_valid;
  logic [4:0]       pw_rd;
  logic [4:0]       pend_reg;

  assign pw_rd       = pw_ir_q[26:22];
  assign pw_div      = (pw_ir_q[6:2] == ALU_DIV);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign issue       = (state == IDLE) && bus.dx_valid && dx_is_md;
  assign pend_valid  = (state != IDLE);
  // an exception retargets the write to the status register, visible to hazards only once WB is reached
  assign pend_reg    = ((state == WB) && exc) ? REG_STATUS : pw_rd;

  md_hazard_check u_hazard (
    .dx_ir      (bus.dx_ir),
    .pend_reg   (pend_reg),
    .pend_valid (pend_valid),
    .raw        (raw),
    .waw        (waw),
    .is_md      (dx_is_md)
  );

  // state register; reset abandons any in-flight operation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // P/W latch, watchdog counter and exception flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pw_ir_q <= 32'd0;
      cnt     <= '0;
      exc     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          pw_ir_q <= bus.dx_ir;
          cnt     <= '0;
          exc     <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.md_result_rdy) exc <= bus.md_exception;
          else if (timeout_hit)  exc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // next state: a ready pulse wins over the watchdog when both land together
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (bus.md_result_rdy || timeout_hit) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: start pulses in IDLE, stall while an op is pending, write port ownership in WB
  always_comb begin
    bus.ctrl_mult    = 1'b0;
    bus.ctrl_div     = 1'b0;
    bus.pw_ir        = pw_ir_q;
    bus.md_busy      = (state != IDLE);
    bus.md_wr_en     = 1'b0;
    bus.md_wr_reg    = 5'd0;
    bus.md_wr_status = 1'b0;
    bus.md_status    = 3'd0;
    bus.stall        = 1'b0;
    bus.mw_hold      = 1'b0;
    case (state)
      IDLE: begin
        bus.ctrl_mult = issue && (bus.dx_ir[6:2] == ALU_MULT);
        bus.ctrl_div  = issue && (bus.dx_ir[6:2] == ALU_DIV);
      end
      BUSY: bus.stall = bus.dx_valid && (dx_is_md || raw || waw);
      WB: begin
        bus.stall        = bus.dx_valid && (dx_is_md || raw || waw);
        bus.md_wr_en     = exc || (pw_rd != 5'd0);
        bus.md_wr_reg    = pend_reg;
        bus.md_wr_status = exc;
        bus.md_status    = exc ? (pw_div ? STATUS_DIV : STATUS_MULT) : 3'd0;
        bus.mw_hold      = bus.mw_wants_write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_wb_sequencer.sv
// tb/tb_multdiv_wb_sequencer.sv - self-checking bench for the mult/div writeback sequencer
module tb_multdiv_wb_sequencer;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  localparam logic [31:0] MUL3     = 32'h00C22018;  // mul $3,$1,$2
  localparam logic [31:0] DIV7     = 32'h01C2201C;  // div $7,$1,$2
  localparam logic [31:0] ADD5_3_4 = 32'h01464000;  // add $5,$3,$4
  localparam logic [31:0] ADD5_304 = 32'h017C4000;  // add $5,$30,$4

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_wb_sequencer_if bus();

  multdiv_wb_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ir;
    logic        valid;
    logic        stall;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input logic [31:0] ir, input logic v, input logic rdy, input logic ex, input logic mw);
    bus.dx_ir          = ir;
    bus.dx_valid       = v;
    bus.md_result_rdy  = rdy;
    bus.md_exception   = ex;
    bus.mw_wants_write = mw;
  endtask

  // reference decode written straight from the instruction-class rules
  function automatic bit ref_is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
  endfunction

  function automatic bit ref_reads(input logic [31:0] ir, input int r);
    int op, rd, rs, rt;
    op = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]); rt = int'(ir[16:12]);
    if (op == 2 || op == 4 || op == 6 || op == 7 || op == 8) return (r == rd) || (r == rs);
    if (op == 0) return (r == rs) || (r == rt);
    return r == rs;
  endfunction

  function automatic int ref_dest(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    if (op == 0 || op == 5 || op == 8) return int'(ir[26:22]);
    if (op == 3) return 31;
    return -1;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] ir;
    ir = $urandom;
    ir[31:27] = 5'($urandom_range(0, 9));
    ir[26:22] = 5'($urandom_range(0, 7));
    ir[21:17] = ($urandom_range(0, 7) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
    ir[16:12] = 5'($urandom_range(0, 7));
    if (ir[31:27] == 5'd0)
      ir[6:2] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(6, 7)) : 5'($urandom_range(0, 5));
    return ir;
  endfunction

  // mult issued, ready withheld; optionally ready arrives exactly on the last watchdog cycle
  task automatic watchdog_run(input logic rdy_last);
    tick(); drive(MUL3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("wd issue", bus.ctrl_mult, 1'b1);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick(); drive(32'd0, 1'b0, rdy_last && (k == TIMEOUT), 1'b0, 1'b0); #1;
      check("wd busy/no-wr", {bus.md_busy, bus.md_wr_en}, 2'b10);
    end
    tick(); drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    check("wd wb wr_en", bus.md_wr_en, 1'b1);
    check("wd wb wr_reg", bus.md_wr_reg, rdy_last ? 5'd3 : 5'd30);
    check("wd wb status", bus.md_status, rdy_last ? 3'd0 : 3'd4);
    check("wd wb wr_status", bus.md_wr_status, !rdy_last);
    tick(); #1;
    check("wd idle after", bus.md_busy, 1'b0);
  endtask

  bit          inflight;
  int          age, wb_age, lat, tgt;
  bit          rexc, fexc;
  logic [31:0] p_ir;
  logic [31:0] r_ir;
  bit          r_v, r_mw, r_rdy, r_ex, wb, e_ctrl, e_stall, e_wen;
  int          e_st;
  logic [46:0] e_vec, a_vec;

  initial begin
    vecs[0]  = '{32'h01464000, 1'b1, 1'b1};  // rs == 3
    vecs[1]  = '{32'h01483000, 1'b1, 1'b1};  // rt == 3
    vecs[2]  = '{32'h00C22000, 1'b1, 1'b1};  // alu writes r3
    vecs[3]  = '{32'h01422000, 1'b1, 1'b0};  // independent add
    vecs[4]  = '{32'h01464000, 1'b0, 1'b0};  // bubble
    vecs[5]  = '{32'h29860000, 1'b1, 1'b1};  // addi reads r3
    vecs[6]  = '{32'h28C20005, 1'b1, 1'b1};  // addi writes r3
    vecs[7]  = '{32'h29020000, 1'b1, 1'b0};  // addi independent
    vecs[8]  = '{32'h10C20000, 1'b1, 1'b1};  // bne reads rd=3
    vecs[9]  = '{32'h38C20000, 1'b1, 1'b1};  // sw reads rd=3
    vecs[10] = '{32'h18000000, 1'b1, 1'b0};  // jal writes r31
    vecs[11] = '{32'h08060000, 1'b1, 1'b1};  // j, rs field 3
    vecs[12] = '{32'h01C2201C, 1'b1, 1'b1};  // second mult/div
    vecs[13] = '{32'h42460000, 1'b1, 1'b1};  // lw reads r3
    vecs[14] = '{32'h42420000, 1'b1, 1'b0};  // lw independent
    vecs[15] = '{32'h20C00000, 1'b1, 1'b1};  // jr reads rd=3
    vecs[16] = '{32'h30C20000, 1'b1, 1'b1};  // blt reads rd=3
    vecs[17] = '{32'h48C20000, 1'b1, 1'b0};  // opcode 9 only reads rs
    vecs[18] = '{32'h00C2200C, 1'b1, 1'b1};  // non-mult alu writes r3

    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset busy", bus.md_busy, 1'b0);
    check("reset pw_ir", bus.pw_ir, 32'd0);
    check("reset wr_en", bus.md_wr_en, 1'b0);
    check("reset ctrl", {bus.ctrl_mult, bus.ctrl_div}, 2'b00);
    check("reset stall/hold", {bus.stall, bus.mw_hold}, 2'b00);
    check("reset wr fields", {bus.md_wr_reg, bus.md_wr_status, bus.md_status}, 9'd0);
    tick(); reset = 1'b1;

    // mult issue with RAW-dependent add behind it, WB collides with M/W write
    tick(); drive(MUL3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("mul ctrl_mult", bus.ctrl_mult, 1'b1);
    check("mul ctrl_div", bus.ctrl_div, 1'b0);
    check("mul issue stall", bus.stall, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick(); drive(ADD5_3_4, 1'b1, c == 10, 1'b0, 1'b0); #1;
      check("mul busy", bus.md_busy, 1'b1);
      check("raw stall busy", bus.stall, 1'b1);
      check("mul no pulse/wr", {bus.ctrl_mult, bus.md_wr_en}, 2'b00);
    end
    tick(); drive(ADD5_3_4, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    check("mul wb wr_en", bus.md_wr_en, 1'b1);
    check("mul wb wr_reg", bus.md_wr_reg, 5'd3);
    check("mul wb status", {bus.md_wr_status, bus.md_status}, 4'd0);
    check("mul wb stall", bus.stall, 1'b1);
    check("mul wb mw_hold", bus.mw_hold, 1'b1);
    check("mul wb busy", bus.md_busy, 1'b1);
    check("mul pw_ir", bus.pw_ir, MUL3);
    tick(); drive(ADD5_3_4, 1'b1, 1'b0, 1'b0, 1'b1); #1;
    check("after wb busy", bus.md_busy, 1'b0);
    check("after wb stall", bus.stall, 1'b0);
    check("after wb mw_hold", bus.mw_hold, 1'b0);
    check("after wb wr_en", bus.md_wr_en, 1'b0);

    // hazard table against pending r3
    tick(); drive(MUL3, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("tbl issue", bus.ctrl_mult, 1'b1);
    for (int i = 0; i < 19; i++) begin
      tick(); drive(vecs[i].ir, vecs[i].valid, 1'b0, 1'b0, 1'b0); #1;
      check($sformatf("tbl stall %0d", i), bus.stall, vecs[i].stall);
      check($sformatf("tbl ctrl %0d", i), {bus.ctrl_mult, bus.ctrl_div}, 2'b00);
    end
    tick(); drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    check("tbl drained", bus.md_busy, 1'b0);

    // divide by zero; r30 reader stalls only in WB
    tick(); drive(DIV7, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("div ctrl", {bus.ctrl_mult, bus.ctrl_div}, 2'b01);
    tick(); drive(ADD5_304, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("div busy r30 no stall", bus.stall, 1'b0);
    tick(); drive(ADD5_304, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    check("div rdy cycle stall", bus.stall, 1'b0);
    tick(); drive(ADD5_304, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    check("div wb wr_en", bus.md_wr_en, 1'b1);
    check("div wb wr_reg", bus.md_wr_reg, 5'd30);
    check("div wb wr_status", bus.md_wr_status, 1'b1);
    check("div wb status", bus.md_status, 3'd5);
    check("div wb r30 stall", bus.stall, 1'b1);
    tick(); #1;
    check("div after stall", bus.stall, 1'b0);

    watchdog_run(1'b0);
    watchdog_run(1'b1);

    // reset mid-operation
    tick(); drive(MUL3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #1;
    check("pre-reset busy", bus.md_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid reset busy", bus.md_busy, 1'b0);
    check("mid reset pw_ir", bus.pw_ir, 32'd0);
    tick(); reset = 1'b1; drive(32'd0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    check("late rdy no wr", bus.md_wr_en, 1'b0);
    tick(); drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    check("late rdy no wr+1", {bus.md_wr_en, bus.md_busy}, 2'b00);

    // randomized run against a transaction-level model
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    inflight = 1'b0; age = 0; wb_age = 0; lat = 0; rexc = 1'b0; fexc = 1'b0; p_ir = 32'd0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_ir  = rand_ir();
      r_v   = ($urandom_range(0, 3) != 0);
      r_mw  = ($urandom_range(0, 1) == 1);
      r_rdy = 1'b0;
      r_ex  = 1'b0;
      if (inflight && age == lat && lat <= TIMEOUT) begin
        r_rdy = 1'b1; r_ex = rexc;
      end else if (!inflight || age == wb_age) begin
        r_rdy = ($urandom_range(0, 4) == 0); r_ex = ($urandom_range(0, 1) == 1);
      end
      tick(); drive(r_ir, r_v, r_rdy, r_ex, r_mw); #1;
      wb      = inflight && (age == wb_age);
      tgt     = (wb && fexc) ? 30 : int'(p_ir[26:22]);
      e_ctrl  = !inflight && r_v && ref_is_md(r_ir);
      e_stall = inflight && r_v &&
                (ref_is_md(r_ir) || (tgt != 0 && (ref_reads(r_ir, tgt) || ref_dest(r_ir) == tgt)));
      e_wen   = wb && (fexc || p_ir[26:22] != 5'd0);
      e_st    = (wb && fexc) ? ((p_ir[6:2] == 5'd7) ? 5 : 4) : 0;
      e_vec   = {e_ctrl && r_ir[6:2] == 5'd6, e_ctrl && r_ir[6:2] == 5'd7, inflight, e_stall,
                 wb && r_mw, e_wen, wb ? 5'(tgt) : 5'd0, wb && fexc, 3'(e_st), p_ir};
      a_vec   = {bus.ctrl_mult, bus.ctrl_div, bus.md_busy, bus.stall, bus.mw_hold, bus.md_wr_en,
                 bus.md_wr_reg, bus.md_wr_status, bus.md_status, bus.pw_ir};
      check($sformatf("random cycle %0d", cyc), a_vec, e_vec);
      if (!inflight) begin
        if (e_ctrl) begin
          inflight = 1'b1;
          age      = 1;
          p_ir     = r_ir;
          lat      = $urandom_range(1, TIMEOUT + 6);
          rexc     = ($urandom_range(0, 3) == 0);
          wb_age   = ((lat < TIMEOUT) ? lat : TIMEOUT) + 1;
          fexc     = (lat <= TIMEOUT) ? rexc : 1'b1;
        end
      end else if (age == wb_age) begin
        inflight = 1'b0;
      end else begin
        age++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
